// File: rtl/if_id_fetch_ctrl_pkg.sv
// rtl/if_id_fetch_ctrl_pkg.sv - shared fetch-control types and constants
package if_id_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter register with redirect/increment next-PC mux
module if_pc_reg
    import if_id_fetch_ctrl_pkg::*;
#(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_branch,
    input  logic             ld_jump,
    input  logic             ld_inc,
    input  logic [NBITS-1:0] branch_target,
    input  logic [NBITS-1:0] jump_target,
    output logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] pc_plus4
);

    assign pc_plus4 = pc + NBITS'(PC_INC);

    // Branch resolves later in the pipe than a jump, so it wins the redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else if (ld_branch) begin
            pc <= branch_target;
        end else if (ld_jump) begin
            pc <= jump_target;
        end else if (ld_inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_id_fetch_ctrl.sv
// rtl/if_id_fetch_ctrl.sv - PC/IF-ID control with stall, flush, debug gating and HALT detection
module if_id_fetch_ctrl
    import if_id_fetch_ctrl_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter logic [NBITS-1:0] PC_RESET  = '0,
    parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic             i_PC_Write,
    input  logic             i_IF_ID_Write,
    input  logic             i_IF_ID_Flush,
    input  logic             i_EX_MEM_Flush,
    input  logic [NBITS-1:0] i_Jump_Target,
    input  logic [NBITS-1:0] i_Branch_Target,
    input  logic [NBITS-1:0] i_Instr,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_IF_ID_Instr,
    output logic [NBITS-1:0] o_IF_ID_PC4,
    output logic             o_IF_ID_Valid,
    output logic             o_Halted,
    output logic             o_Step_Done,
    output logic [31:0]      o_Cycles
);

    fetch_state_e     state;
    logic             adv;
    logic             flush;
    logic             halt_hit;
    logic [NBITS-1:0] pc_plus4;

    assign adv      = (state == S_RUN) && (!i_step_mode || i_step);
    assign flush    = i_IF_ID_Flush || i_EX_MEM_Flush;
    // Only an instruction that actually lands in IF/ID can stop fetch.
    assign halt_hit = adv && !flush && i_IF_ID_Write && (i_Instr == HALT_WORD);

    if_pc_reg #(
        .NBITS    (NBITS),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk           (i_clk),
        .rst_n         (i_reset),
        .ld_branch     (adv && i_EX_MEM_Flush),
        .ld_jump       (adv && i_IF_ID_Flush),
        .ld_inc        (adv && i_PC_Write && !halt_hit),
        .branch_target (i_Branch_Target),
        .jump_target   (i_Jump_Target),
        .pc            (o_PC),
        .pc_plus4      (pc_plus4)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= S_IDLE;
            o_IF_ID_Instr <= '0;
            o_IF_ID_PC4   <= '0;
            o_IF_ID_Valid <= 1'b0;
            o_Halted      <= 1'b0;
            o_Step_Done   <= 1'b0;
            o_Cycles      <= 32'd0;
        end else begin
            o_Step_Done <= adv && i_step_mode;

            if (adv) begin
                o_Cycles <= o_Cycles + 32'd1;
            end

            // A flush beats a stall; a halted pipe keeps draining bubbles.
            if ((state == S_HALT) || (adv && flush)) begin
                o_IF_ID_Instr <= NBITS'(NOP_WORD);
                o_IF_ID_PC4   <= '0;
                o_IF_ID_Valid <= 1'b0;
            end else if (adv && i_IF_ID_Write) begin
                o_IF_ID_Instr <= i_Instr;
                o_IF_ID_PC4   <= pc_plus4;
                o_IF_ID_Valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt_hit) begin
                        state    <= S_HALT;
                        o_Halted <= 1'b1;
                    end else if (!i_enable) begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb/tb_if_id_fetch_ctrl.sv - self-checking bench for if_id_fetch_ctrl
module tb_if_id_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NORM = 32'h0000_1234;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, smode = 1'b0, step = 1'b0;
    logic        pcw = 1'b1, ifw = 1'b1, jf = 1'b0, bf = 1'b0;
    logic [31:0] jt = '0, bt = '0, instr = NORM;

    logic [31:0] pc, id_instr, id_pc4, cycles;
    logic        id_valid, halted, step_done;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // Reference model state
    int          m_state;
    logic [31:0] m_pc, m_instr, m_pc4, m_cycles;
    logic        m_valid, m_halted, m_step_done;

    always #5 clk = ~clk;

    if_id_fetch_ctrl dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_enable        (en),
        .i_step_mode     (smode),
        .i_step          (step),
        .i_PC_Write      (pcw),
        .i_IF_ID_Write   (ifw),
        .i_IF_ID_Flush   (jf),
        .i_EX_MEM_Flush  (bf),
        .i_Jump_Target   (jt),
        .i_Branch_Target (bt),
        .i_Instr         (instr),
        .o_PC            (pc),
        .o_IF_ID_Instr   (id_instr),
        .o_IF_ID_PC4     (id_pc4),
        .o_IF_ID_Valid   (id_valid),
        .o_Halted        (halted),
        .o_Step_Done     (step_done),
        .o_Cycles        (cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_step_done = 1'b0; m_cycles = 32'h0;
        end else begin
            bit adv, fl, hit;
            int nxt;
            adv = (m_state == M_RUN) && (!smode || step);
            fl  = jf || bf;
            hit = adv && !fl && ifw && (instr == HALT);
            nxt = m_state;
            if (m_state == M_IDLE && en) nxt = M_RUN;
            else if (m_state == M_RUN) begin
                if (hit) nxt = M_HALT;
                else if (!en) nxt = M_IDLE;
            end
            m_step_done = adv && smode;
            if (m_state == M_HALT) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (adv) begin
                if (fl) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end else if (ifw) begin
                    m_instr = instr; m_pc4 = m_pc + 4; m_valid = 1;
                end
                if (bf) m_pc = bt;
                else if (jf) m_pc = jt;
                else if (pcw && !hit) m_pc = m_pc + 4;
                m_cycles = m_cycles + 1;
            end
            if (hit) m_halted = 1'b1;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc", pc, m_pc);
            chk("m_instr", id_instr, m_instr);
            chk("m_pc4", id_pc4, m_pc4);
            chk("m_valid", {31'b0, id_valid}, {31'b0, m_valid});
            chk("m_halted", {31'b0, halted}, {31'b0, m_halted});
            chk("m_step_done", {31'b0, step_done}, {31'b0, m_step_done});
            chk("m_cycles", cycles, m_cycles);
        end
    end

    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        en = 1; smode = 0; pcw = 1; ifw = 1; instr = NORM;
        do_reset();
        cmp_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_cycles", cycles, 32'h0);
        chk("rst_instr", id_instr, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk("run_pc4", pc, 32'h4); chk("run_id_pc4", id_pc4, 32'h4);
        chk("run_valid", {31'b0, id_valid}, 32'h1); chk("run_instr", id_instr, NORM);
        @(negedge clk);
        chk("run_pc8", pc, 32'h8); chk("run_id_pc8", id_pc4, 32'h8); chk("run_cyc2", cycles, 32'd2);
        pcw = 0; ifw = 0;
        @(negedge clk);
        chk("stall_pc", pc, 32'h8); chk("stall_id_pc4", id_pc4, 32'h8);
        pcw = 1; ifw = 1;
        @(negedge clk);
        chk("resume_pc", pc, 32'hC); chk("resume_id_pc4", id_pc4, 32'hC);
        @(negedge clk);
        chk("pre_br_pc", pc, 32'h10);
        bf = 1; bt = 32'h40; jf = 1; jt = 32'h80; ifw = 0;
        @(negedge clk);
        chk("br_pc", pc, 32'h40); chk("br_instr", id_instr, 32'h0);
        chk("br_valid", {31'b0, id_valid}, 32'h0);
        bf = 0; ifw = 1; jt = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("jmp_pc", pc, 32'hFFFF_FFFC);
        jf = 0;
        @(negedge clk);
        chk("wrap_pc", pc, 32'h0); chk("wrap_id_pc4", id_pc4, 32'h0);

        smode = 1; step = 0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            step = 1;
            @(negedge clk);
            chk("step_done_hi", {31'b0, step_done}, 32'h1);
            chk("step_pc", pc, 32'(4 * (k + 1)));
            step = 0;
            @(negedge clk);
            chk("step_done_lo", {31'b0, step_done}, 32'h0);
        end
        chk("step_cycles", cycles, 32'd3);

        smode = 0;
        do_reset();
        repeat (6) @(negedge clk);
        chk("pre_halt_pc", pc, 32'h14);
        instr = HALT;
        @(negedge clk);
        chk("halt_instr", id_instr, HALT); chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_pc", pc, 32'h14); chk("halt_pc4", id_pc4, 32'h18);
        instr = NORM;
        @(negedge clk);
        chk("halt_bubble", id_instr, 32'h0); chk("halt_bvalid", {31'b0, id_valid}, 32'h0);
        chk("halt_pc_hold", pc, 32'h14); chk("halt_cycles", cycles, 32'd6);

        do_reset();
        repeat (3) @(negedge clk);
        chk("pre_fh_pc", pc, 32'h8);
        instr = HALT; jf = 1; jt = 32'h18;
        @(negedge clk);
        chk("fh_nohalt", {31'b0, halted}, 32'h0); chk("fh_pc", pc, 32'h18);
        instr = NORM; jf = 0;
        repeat (2) @(negedge clk);
        chk("pre_async_pc", pc, 32'h20);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0); chk("async_instr", id_instr, 32'h0);
        chk("async_pc4", id_pc4, 32'h0); chk("async_valid", {31'b0, id_valid}, 32'h0);
        chk("async_cycles", cycles, 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            rst_n = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 9) != 0);
            smode = ($urandom_range(0, 4) == 0);
            step  = $urandom_range(0, 1) == 1;
            pcw   = ($urandom_range(0, 6) != 0);
            ifw   = ($urandom_range(0, 6) != 0);
            jf    = ($urandom_range(0, 9) == 0);
            bf    = ($urandom_range(0, 9) == 0);
            jt    = $urandom & 32'hFFFF_FFFC;
            bt    = $urandom & 32'hFFFF_FFFC;
            instr = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
